// File: rtl/kan_ctrl_pkg.sv
// kan_ctrl_pkg: state encodings and status codes shared by the splitter sequencer
package kan_ctrl_pkg;
`ifdef USE_ONE_HOT_ENCODING_FSM
  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_RUN    = 5'b00100,
    S_FLUSH  = 5'b01000,
    S_REPORT = 5'b10000
  } seq_state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_RUN    = 3'd2,
    S_FLUSH  = 3'd3,
    S_REPORT = 3'd4
  } seq_state_t;
`endif
  localparam logic [1:0] STS_OK        = 2'd0;
  localparam logic [1:0] STS_SPLIT_ERR = 2'd1;
  localparam logic [1:0] STS_TIMEOUT   = 2'd2;
  localparam logic [1:0] STS_ABORT     = 2'd3;
endpackage

// File: rtl/sequencer_watchdog.sv
// sequencer_watchdog: no-progress counter with clear/enable/freeze and terminal-count pulse
// Ports: i_clr zeroes the count, i_en lets it advance, i_frz holds it, o_tc flags the cycle the count reaches TMO_CYCLES.
module sequencer_watchdog #(
  parameter int TMO_WIDTH  = 16,
  parameter int TMO_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_frz,
  output logic o_tc
);
  logic [TMO_WIDTH-1:0] r_cnt;
  logic                 w_inc;
  assign w_inc = (TMO_CYCLES != 0) && i_en && !i_clr && !i_frz;
  // Fires on the idle cycle that brings the count to TMO_CYCLES, so a beat in that cycle suppresses it.
  assign o_tc  = w_inc && (r_cnt == TMO_WIDTH'(TMO_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (w_inc) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/axis_splitter_sequencer.sv
// axis_splitter_sequencer: runs the AXI-Stream splitter repeat times per command under watchdog/abort supervision
// Ports: cmd_* job command (valid/ready), sts_* one status word per job (valid/ready),
//        ctl_* splitter control and interrupt pins, abort/pause host controls, busy when not idle.
module axis_splitter_sequencer
  import kan_ctrl_pkg::*;
#(
  parameter int PCKT_WIDTH = 32,
  parameter int REP_WIDTH  = 16,
  parameter int TMO_WIDTH  = 16,
  parameter int TMO_CYCLES = 4096,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [PCKT_WIDTH-1:0] cmd_pckt_size,
  input  logic [REP_WIDTH-1:0]  cmd_repeat,
  input  logic                  abort,
  input  logic                  pause,
  output logic                  sts_valid,
  input  logic                  sts_ready,
  output logic [1:0]            sts_code,
  output logic [BEAT_WIDTH-1:0] sts_beats,
  output logic [REP_WIDTH-1:0]  sts_done_ops,
  output logic                  ctl_operation_start,
  output logic [PCKT_WIDTH-1:0] ctl_pckt_size,
  output logic                  ctl_lock,
  output logic                  ctl_external_error,
  input  logic                  ctl_operation_busy,
  input  logic                  ctl_operation_complete,
  input  logic                  ctl_operation_error,
  input  logic                  ctl_transmission,
  output logic                  busy
);
  seq_state_t            r_state, w_next;
  logic [PCKT_WIDTH-1:0] r_size;
  logic [REP_WIDTH-1:0]  r_rep, r_ops;
  logic [BEAT_WIDTH-1:0] r_beats;
  logic [1:0]            r_code, w_code;
  logic                  r_wait, w_wait;
  logic                  r_start, r_lock, r_ext_err, r_sts_valid, r_busy;
  logic                  w_accept, w_tc, w_ext_err, w_set_code, w_ops_inc, w_count_beat;
  logic                  w_unused;
  // Operation busy is informational only: the watchdog already starts at START exit.
  assign w_unused     = ctl_operation_busy;
  assign cmd_ready    = (r_state == S_IDLE) && !rst;
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_count_beat = ctl_transmission && (r_state == S_START || r_state == S_RUN || r_state == S_FLUSH);
  sequencer_watchdog #(
    .TMO_WIDTH (TMO_WIDTH),
    .TMO_CYCLES(TMO_CYCLES)
  ) u_wdog (
    .clk  (clk),
    .rst  (rst),
    .i_clr(w_accept || r_state == S_START || ctl_transmission),
    .i_en (r_state == S_RUN),
    .i_frz(pause),
    .o_tc (w_tc)
  );
  always_comb begin
    w_next     = r_state;
    w_code     = STS_OK;
    w_set_code = 1'b0;
    w_wait     = r_wait;
    w_ext_err  = 1'b0;
    w_ops_inc  = 1'b0;
    case (r_state)
      S_IDLE:  w_next = w_accept ? S_START : S_IDLE;
      S_START: w_next = S_RUN;
      S_RUN: begin
        if (ctl_operation_error) begin
          w_next     = S_FLUSH;
          w_code     = STS_SPLIT_ERR;
          w_set_code = 1'b1;
          w_wait     = 1'b0;
        end else if (abort || w_tc) begin
          // The splitter answers external_error with operation_error; FLUSH waits for it.
          w_next     = S_FLUSH;
          w_code     = abort ? STS_ABORT : STS_TIMEOUT;
          w_set_code = 1'b1;
          w_wait     = 1'b1;
          w_ext_err  = 1'b1;
        end else if (ctl_operation_complete) begin
          w_ops_inc  = 1'b1;
          w_next     = (r_ops + 1'b1 == r_rep) ? S_REPORT : S_START;
          w_set_code = (r_ops + 1'b1 == r_rep);
        end
      end
      S_FLUSH:  w_next = (!r_wait || ctl_operation_error) ? S_REPORT : S_FLUSH;
      S_REPORT: w_next = sts_ready ? S_IDLE : S_REPORT;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_size      <= '0;
      r_rep       <= '0;
      r_ops       <= '0;
      r_beats     <= '0;
      r_code      <= STS_OK;
      r_wait      <= 1'b0;
      r_start     <= 1'b0;
      r_lock      <= 1'b0;
      r_ext_err   <= 1'b0;
      r_sts_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_start     <= w_next == S_START;
      r_busy      <= w_next != S_IDLE;
      r_sts_valid <= w_next == S_REPORT;
      r_lock      <= pause && w_next == S_RUN;
      r_ext_err   <= w_ext_err;
      if (w_accept) begin
        r_size  <= cmd_pckt_size;
        r_rep   <= (cmd_repeat == '0) ? REP_WIDTH'(1) : cmd_repeat;
        r_ops   <= '0;
        r_beats <= '0;
        r_code  <= STS_OK;
        r_wait  <= 1'b0;
      end else begin
        r_wait <= w_wait;
        if (w_count_beat && !(&r_beats)) r_beats <= r_beats + 1'b1;
        if (w_ops_inc) r_ops <= r_ops + 1'b1;
        if (w_set_code) r_code <= w_code;
      end
    end
  end
  assign ctl_operation_start = r_start;
  assign ctl_pckt_size       = r_size;
  assign ctl_lock            = r_lock;
  assign ctl_external_error  = r_ext_err;
  assign sts_valid           = r_sts_valid;
  assign sts_code            = r_code;
  assign sts_beats           = r_beats;
  assign sts_done_ops        = r_ops;
  assign busy                = r_busy;
endmodule

// File: tb/tb_axis_splitter_sequencer.sv
// tb_axis_splitter_sequencer: directed and randomized jobs against a behavioural splitter and job-level expectations
module tb_axis_splitter_sequencer;
  localparam int TMO = 16;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_pckt_size = '0;
  logic [15:0] cmd_repeat = '0;
  logic        tb_abort = 1'b0, m_abort = 1'b0, abort;
  logic        pause = 1'b0, sts_ready = 1'b0;
  logic        sp_busy = 1'b0, sp_complete = 1'b0, sp_error = 1'b0, sp_tx = 1'b0;
  logic        cmd_ready, sts_valid, busy;
  logic [1:0]  sts_code;
  logic [31:0] sts_beats, ctl_pckt_size;
  logic [15:0] sts_done_ops;
  logic        ctl_operation_start, ctl_lock, ctl_external_error;
  int checks = 0, errors = 0;
  int m_stall_after = -1, m_err_at = -1, m_gap_max = 0, m_rep = 1, m_done = 0;
  bit m_abort_final = 0;
  int cyc = 0, n_start = 0, n_ext = 0, last_tx = -1, last_cmp = -1, ext_cyc = -1, rise_cyc = -1, gap_bad = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;
  assign abort = tb_abort | m_abort;

  axis_splitter_sequencer #(.TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_pckt_size(cmd_pckt_size), .cmd_repeat(cmd_repeat),
    .abort(abort), .pause(pause),
    .sts_valid(sts_valid), .sts_ready(sts_ready), .sts_code(sts_code), .sts_beats(sts_beats), .sts_done_ops(sts_done_ops),
    .ctl_operation_start(ctl_operation_start), .ctl_pckt_size(ctl_pckt_size), .ctl_lock(ctl_lock),
    .ctl_external_error(ctl_external_error), .ctl_operation_busy(sp_busy),
    .ctl_operation_complete(sp_complete), .ctl_operation_error(sp_error), .ctl_transmission(sp_tx),
    .busy(busy)
  );

  // Behavioural splitter: streams size beats with random gaps, freezes under lock,
  // answers external_error with operation_error, and can stall or cut a packet short.
  initial begin
    int left, sent, gap;
    bit act;
    act = 0; left = 0; sent = 0; gap = 0;
    forever begin
      @(posedge clk); #1;
      sp_tx = 0; sp_complete = 0; sp_error = 0; m_abort = 0;
      if (rst) act = 0;
      else if (ctl_external_error) begin sp_error = 1; act = 0; end
      else if (ctl_operation_start) begin
        act = 1; left = int'(ctl_pckt_size); sent = 0; gap = $urandom_range(m_gap_max, 0);
      end else if (act) begin
        if (left == 0) begin
          sp_complete = 1; act = 0; m_done++;
          if (m_abort_final && m_done == m_rep) m_abort = 1;
        end else if (sent == m_err_at) begin sp_error = 1; act = 0; end
        else if (sent == m_stall_after || ctl_lock) begin end
        else if (gap > 0) gap--;
        else begin sp_tx = 1; sent++; left--; gap = $urandom_range(m_gap_max, 0); end
      end
      sp_busy = act;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #3;
      cyc++;
      if (ctl_operation_start) begin
        n_start++;
        if (last_cmp >= 0 && (cyc - last_cmp < 1 || cyc - last_cmp > 2)) gap_bad++;
        last_cmp = -1;
      end
      if (sp_complete) last_cmp = cyc;
      if (ctl_external_error) begin n_ext++; ext_cyc = cyc; end
      if (sp_tx) last_tx = cyc;
      if (sts_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = sts_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit observed=expired expected=finish");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic prep(input int rep, input int gmax);
    m_done = 0; m_rep = (rep == 0) ? 1 : rep; m_gap_max = gmax;
    n_start = 0; n_ext = 0; last_cmp = -1; ext_cyc = -1; rise_cyc = -1; gap_bad = 0; last_tx = -1;
  endtask

  task automatic send_cmd(input int sz, input int rp);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_pckt_size = sz; cmd_repeat = rp;
    @(negedge clk);
    cmd_valid = 0;
    chk("start_latency", ctl_operation_start, 1);
    chk("ctl_pckt_size", ctl_pckt_size, sz);
  endtask

  task automatic finish_job(input string tag, input int code, input int beats, input int ops);
    int n;
    n = 0;
    while (!sts_valid && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_sts_valid"}, sts_valid, 1);
    repeat ($urandom_range(3, 0)) @(negedge clk);
    chk({tag, "_sts_hold"}, sts_valid, 1);
    chk({tag, "_code"}, sts_code, code);
    chk({tag, "_beats"}, sts_beats, beats);
    chk({tag, "_ops"}, sts_done_ops, ops);
    sts_ready = 1;
    @(negedge clk);
    sts_ready = 0;
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_valid_after"}, sts_valid, 0);
  endtask

  task automatic ok_job(input string tag, input int sz, input int rp, input int gmax);
    int ops;
    ops = (rp == 0) ? 1 : rp;
    prep(rp, gmax);
    send_cmd(sz, rp);
    finish_job(tag, 0, sz * ops, ops);
    chk({tag, "_starts"}, n_start, ops);
    chk({tag, "_no_ext_err"}, n_ext, 0);
    chk({tag, "_start_gap"}, gap_bad, 0);
    chk({tag, "_final_to_sts"}, rise_cyc - last_cmp, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sts_valid", sts_valid, 0);
    chk("rst_start", ctl_operation_start, 0);
    chk("rst_pckt_size", ctl_pckt_size, 0);
    chk("rst_lock", ctl_lock, 0);
    chk("rst_ext_err", ctl_external_error, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_cmd_ready", cmd_ready, 1);

    ok_job("s4r3", 4, 3, 0);
    ok_job("rep0", 2, 0, 1);

    prep(1, 0);
    m_stall_after = 1;
    send_cmd(4, 1);
    finish_job("timeout", 2, 1, 0);
    chk("timeout_ext_pulses", n_ext, 1);
    chk("timeout_idle_cycles", ext_cyc - last_tx, TMO + 1);
    m_stall_after = -1;

    prep(1, 0);
    m_err_at = 3;
    send_cmd(4, 1);
    finish_job("split_err", 1, 3, 0);
    chk("split_err_no_ext", n_ext, 0);
    m_err_at = -1;

    prep(2, 0);
    m_abort_final = 1;
    send_cmd(2, 2);
    finish_job("abort_final", 3, 4, 1);
    chk("abort_final_ext", n_ext, 1);
    m_abort_final = 0;

    prep(1, 2);
    pause = 1;
    send_cmd(3, 1);
    repeat (100) @(negedge clk);
    chk("pause_no_timeout", n_ext, 0);
    chk("pause_lock", ctl_lock, 1);
    chk("pause_busy", busy, 1);
    chk("pause_no_sts", sts_valid, 0);
    pause = 0;
    finish_job("pause", 0, 3, 1);

    pause = 1; tb_abort = 1;
    repeat (2) @(negedge clk);
    chk("idle_lock_ignored", ctl_lock, 0);
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_ext", n_ext, 0);
    pause = 0; tb_abort = 0;

    prep(2, 2);
    send_cmd(8, 2);
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_beats", sts_beats, 0);
    chk("midrst_ops", sts_done_ops, 0);
    chk("midrst_size", ctl_pckt_size, 0);
    chk("midrst_ready", cmd_ready, 1);
    repeat (5) @(negedge clk);
    chk("midrst_no_sts", sts_valid, 0);
    ok_job("after_rst", 3, 2, 1);

    for (int i = 0; i < 8; i++)
      ok_job("rand", $urandom_range(6, 1), $urandom_range(4, 0), $urandom_range(3, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
